// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the demux_1xn_lanes block.
//   ST_IDLE / ST_FILL : state encoding of the lane-fill state machine.
//   demux_ptr_width() : width of a pointer/counter covering n values (>= 1 bit).
package demux_pkg;

  localparam logic ST_IDLE = 1'b0;  // ptr == 0, nothing staged
  localparam logic ST_FILL = 1'b1;  // at least one lane staged

  function automatic int demux_ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_idle_timer.sv
// demux_idle_timer: counts consecutive idle cycles while a partial group is
// staged and raises a one-cycle flush request on the cycle that ends the
// TIMEOUT-th consecutive idle cycle. Only instantiated when TIMEOUT > 0.
// Ports:
//   clk, reset_L : clock, asynchronous active-low reset
//   in_fill      : 1 while the parent state machine is in ST_FILL
//   valid_in     : input word qualifier (any word clears the count)
//   align        : group restart (clears the count, suppresses flush)
//   flush        : combinational flush request for the current cycle
module demux_idle_timer
  import demux_pkg::*;
#(
  parameter int TIMEOUT = 3
) (
  input  logic clk,
  input  logic reset_L,
  input  logic in_fill,
  input  logic valid_in,
  input  logic align,
  output logic flush
);

  localparam int CW = demux_ptr_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // The count never exceeds TIMEOUT-1: reaching it in an idle cycle flushes,
  // which returns the parent to ST_IDLE and clears the count.
  assign flush = in_fill && !valid_in && !align && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= '0;
    end else if (!in_fill || valid_in || align || flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/demux_1xn_lanes.sv
// demux_1xn_lanes: unstripes a single word stream round-robin onto N_CH lanes
// and presents each completed (or timed-out partial) group in one cycle.
// Optional feature macro: DEMUX_LANE_PARITY_EN adds parity_out.
// Ports:
//   clk, reset_L : clock, asynchronous active-low reset
//   data_in      : WIDTH-bit input word
//   valid_in     : data_in qualifier
//   align        : restart the group; the next stored word goes to lane 0
//   data_out     : lane k at [k*WIDTH +: WIDTH], held between updates
//   valid_out    : per-lane one-cycle strobe for the lanes updated last edge
//   parity_out   : (DEMUX_LANE_PARITY_EN) XOR-reduce of each lane word
//   state_out    : debug, current state (ST_IDLE / ST_FILL)
//   ptr_out      : debug, current fill pointer
//
// Handshake: the input is a valid-only stream with no backpressure; every
// cycle with valid_in=1 consumes data_in. Outputs carry no ready either: a
// lane strobe in valid_out is asserted for exactly one cycle and the data
// remains on data_out until that lane is next written.
module demux_1xn_lanes
  import demux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 3
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          valid_in,
  input  logic                          align,
  output logic [N_CH*WIDTH-1:0]         data_out,
  output logic [N_CH-1:0]               valid_out,
`ifdef DEMUX_LANE_PARITY_EN
  output logic [N_CH-1:0]               parity_out,
`endif
  output logic                          state_out,
  output logic [demux_ptr_width(N_CH)-1:0] ptr_out
);

  localparam int PW = demux_ptr_width(N_CH);
  localparam logic [PW-1:0] LAST = PW'(N_CH - 1);

  logic             state;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] stage [N_CH];
  logic [N_CH-1:0]  out_we;
  logic             complete;
  logic             flush;

  // align outranks both completion and flush: a restart never emits data.
  assign complete  = valid_in && !align && (ptr == LAST);
  assign state_out = state;
  assign ptr_out   = ptr;

  if (TIMEOUT > 0) begin : g_timer
    demux_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
      .clk      (clk),
      .reset_L  (reset_L),
      .in_fill  (state == ST_FILL),
      .valid_in (valid_in),
      .align    (align),
      .flush    (flush)
    );
  end else begin : g_no_timer
    assign flush = 1'b0;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic [WIDTH-1:0] lane_q;
    logic [WIDTH-1:0] lane_word;

    // On completion the last lane comes straight from data_in, so a full
    // group is emitted on the same edge that samples its final word.
    if (k == N_CH - 1) begin : g_last
      assign lane_word = data_in;
    end else begin : g_mid
      assign lane_word = stage[k];
    end

    assign out_we[k] = complete || (flush && (PW'(k) < ptr));
    assign data_out[k*WIDTH +: WIDTH] = lane_q;

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        stage[k] <= '0;
      end else if (valid_in && (align ? (k == 0) : (ptr == PW'(k)))) begin
        stage[k] <= data_in;
      end
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        lane_q <= '0;
      end else if (out_we[k]) begin
        lane_q <= lane_word;
      end
    end

`ifdef DEMUX_LANE_PARITY_EN
    logic par_q;
    assign parity_out[k] = par_q;

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        par_q <= 1'b0;
      end else if (out_we[k]) begin
        par_q <= ^lane_word;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      valid_out <= '0;
    end else begin
      valid_out <= out_we;
      if (align) begin
        if (valid_in) begin
          ptr   <= PW'(1);
          state <= ST_FILL;
        end else begin
          ptr   <= '0;
          state <= ST_IDLE;
        end
      end else if (valid_in) begin
        if (ptr == LAST) begin
          ptr   <= '0;
          state <= ST_IDLE;
        end else begin
          ptr   <= ptr + PW'(1);
          state <= ST_FILL;
        end
      end else if (flush) begin
        ptr   <= '0;
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_demux_1xn_lanes.sv
module tb_demux_1xn_lanes;

  localparam int WIDTH   = 8;
  localparam int N_CH    = 4;
  localparam int TIMEOUT = 3;

  logic                  clk;
  logic                  reset_L;
  logic [WIDTH-1:0]      data_in;
  logic                  valid_in;
  logic                  align;
  logic [N_CH*WIDTH-1:0] data_out;
  logic [N_CH-1:0]       valid_out;
`ifdef DEMUX_LANE_PARITY_EN
  logic [N_CH-1:0]       parity_out;
`endif
  logic                  state_out;
  logic [1:0]            ptr_out;

  demux_1xn_lanes #(.WIDTH(WIDTH), .N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .align      (align),
    .data_out   (data_out),
    .valid_out  (valid_out),
`ifdef DEMUX_LANE_PARITY_EN
    .parity_out (parity_out),
`endif
    .state_out  (state_out),
    .ptr_out    (ptr_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters, scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [N_CH*WIDTH-1:0] exp_q[$];

  // Reference model: a queue of staged words, an idle-cycle count, and the
  // last values presented on the outputs.
  logic [WIDTH-1:0]      m_stage[$];
  int                    m_idle;
  logic [N_CH*WIDTH-1:0] m_data;
  logic [N_CH-1:0]       m_valid;

  typedef struct {
    bit               v;
    bit               a;
    logic [WIDTH-1:0] d;
    logic [31:0]      e_data;
    logic [3:0]       e_valid;
    logic [1:0]       e_ptr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] lane_parity(input logic [N_CH*WIDTH-1:0] d);
    logic [N_CH-1:0] p;
    for (int k = 0; k < N_CH; k++) p[k] = ^d[k*WIDTH +: WIDTH];
    return p;
  endfunction

  task automatic model_reset();
    m_stage.delete();
    m_idle  = 0;
    m_data  = '0;
    m_valid = '0;
  endtask

  task automatic model_step(input bit v, input bit a, input logic [WIDTH-1:0] d);
    m_valid = '0;
    if (a) begin
      m_stage.delete();
      m_idle = 0;
      if (v) m_stage.push_back(d);
    end else if (v) begin
      m_idle = 0;
      m_stage.push_back(d);
      if (m_stage.size() == N_CH) begin
        for (int k = 0; k < N_CH; k++) m_data[k*WIDTH +: WIDTH] = m_stage[k];
        m_valid = '1;
        m_stage.delete();
      end
    end else if (m_stage.size() > 0) begin
      m_idle++;
      if (TIMEOUT > 0 && m_idle == TIMEOUT) begin
        for (int k = 0; k < m_stage.size(); k++) begin
          m_data[k*WIDTH +: WIDTH] = m_stage[k];
          m_valid[k] = 1'b1;
        end
        m_stage.delete();
        m_idle = 0;
      end
    end
    if (m_valid != '0) exp_q.push_back(m_data);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit a, input logic [WIDTH-1:0] d);
    valid_in = v;
    align    = a;
    data_in  = d;
    @(posedge clk);
    #1;
    model_step(v, a, d);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid_out"}, valid_out, m_valid);
    chk({tag, ".data_out"},  data_out,  m_data);
    chk({tag, ".ptr_out"},   ptr_out,   m_stage.size());
    chk({tag, ".state_out"}, state_out, m_stage.size() != 0);
    if (m_valid != '0) begin
      if (exp_q.size() == 0) chk({tag, ".exp_q_empty"}, 1, 0);
      else chk({tag, ".group"}, data_out, exp_q.pop_front());
    end
`ifdef DEMUX_LANE_PARITY_EN
    chk({tag, ".parity_out"}, parity_out, lane_parity(m_data));
`endif
  endtask

  task automatic add(input bit v, input bit a, input logic [7:0] d,
                     input logic [31:0] ed, input logic [3:0] ev, input logic [1:0] ep);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.e_data = ed; t.e_valid = ev; t.e_ptr = ep;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    align    = 1'b0;
    data_in  = '0;
    #2 reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    reset_L  = 1'b1;
    valid_in = 1'b0;
    align    = 1'b0;
    data_in  = '0;
    model_reset();

    // Full group, then one idle cycle to show the strobe is single-cycle.
    add(1, 0, 8'h11, 32'h0,        4'b0000, 2'd1);
    add(1, 0, 8'h22, 32'h0,        4'b0000, 2'd2);
    add(1, 0, 8'h33, 32'h0,        4'b0000, 2'd3);
    add(1, 0, 8'h44, 32'h44332211, 4'b1111, 2'd0);
    add(0, 0, 8'h00, 32'h44332211, 4'b0000, 2'd0);
    // Gapped group: two idle cycles is below the timeout.
    add(1, 0, 8'hA1, 32'h44332211, 4'b0000, 2'd1);
    add(0, 0, 8'h00, 32'h44332211, 4'b0000, 2'd1);
    add(0, 0, 8'h00, 32'h44332211, 4'b0000, 2'd1);
    add(1, 0, 8'hA2, 32'h44332211, 4'b0000, 2'd2);
    add(1, 0, 8'hA3, 32'h44332211, 4'b0000, 2'd3);
    add(1, 0, 8'hA4, 32'hA4A3A2A1, 4'b1111, 2'd0);
    // Partial flush on the third idle cycle; lanes 2-3 keep A4/A3.
    add(1, 0, 8'h55, 32'hA4A3A2A1, 4'b0000, 2'd1);
    add(1, 0, 8'h66, 32'hA4A3A2A1, 4'b0000, 2'd2);
    add(0, 0, 8'h00, 32'hA4A3A2A1, 4'b0000, 2'd2);
    add(0, 0, 8'h00, 32'hA4A3A2A1, 4'b0000, 2'd2);
    add(0, 0, 8'h00, 32'hA4A36655, 4'b0011, 2'd0);
    add(0, 0, 8'h00, 32'hA4A36655, 4'b0000, 2'd0);
    // Align with data restarts the group; 0x01/0x02 are dropped.
    add(1, 0, 8'h01, 32'hA4A36655, 4'b0000, 2'd1);
    add(1, 0, 8'h02, 32'hA4A36655, 4'b0000, 2'd2);
    add(1, 1, 8'h10, 32'hA4A36655, 4'b0000, 2'd1);
    add(1, 0, 8'h20, 32'hA4A36655, 4'b0000, 2'd2);
    add(1, 0, 8'h30, 32'hA4A36655, 4'b0000, 2'd3);
    add(1, 0, 8'h40, 32'h40302010, 4'b1111, 2'd0);
    // Align without data mid-group discards silently; no flush afterwards.
    add(1, 0, 8'h99, 32'h40302010, 4'b0000, 2'd1);
    add(0, 1, 8'h00, 32'h40302010, 4'b0000, 2'd0);
    add(0, 0, 8'h00, 32'h40302010, 4'b0000, 2'd0);
    add(0, 0, 8'h00, 32'h40302010, 4'b0000, 2'd0);
    add(0, 0, 8'h00, 32'h40302010, 4'b0000, 2'd0);

    do_reset();
    chk("reset.data_out",  data_out,  0);
    chk("reset.valid_out", valid_out, 0);
    chk("reset.ptr_out",   ptr_out,   0);
    chk("reset.state_out", state_out, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d.data_out", i),  data_out,  tbl[i].e_data);
      chk($sformatf("tbl%0d.valid_out", i), valid_out, tbl[i].e_valid);
      chk($sformatf("tbl%0d.ptr_out", i),   ptr_out,   tbl[i].e_ptr);
`ifdef DEMUX_LANE_PARITY_EN
      chk($sformatf("tbl%0d.parity_out", i), parity_out, lane_parity(tbl[i].e_data));
`endif
    end

    // Reset mid-group: outputs clear asynchronously, before any clock edge.
    drive(1, 0, 8'h77);
    drive(1, 0, 8'h88);
    chk("midrst.ptr_before", ptr_out, 2);
    valid_in = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    chk("midrst.data_out",  data_out,  0);
    chk("midrst.valid_out", valid_out, 0);
    chk("midrst.ptr_out",   ptr_out,   0);
`ifdef DEMUX_LANE_PARITY_EN
    chk("midrst.parity_out", parity_out, 0);
`endif
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1 reset_L = 1'b1;
    drive(1, 0, 8'hC1); chk_model("post_rst0");
    drive(1, 0, 8'hC2); chk_model("post_rst1");
    drive(1, 0, 8'hC3); chk_model("post_rst2");
    drive(1, 0, 8'hC4); chk_model("post_rst3");
    chk("post_rst.group", data_out, 32'hC4C3C2C1);

`ifdef DEMUX_LANE_PARITY_EN
    drive(1, 0, 8'h01);
    drive(1, 0, 8'h03);
    drive(1, 0, 8'h07);
    drive(1, 0, 8'h00);
    chk("parity.group", parity_out, 4'b0101);
`endif

    // Randomized traffic with idle bursts and occasional align.
    do_reset();
    begin
      int idle_run;
      idle_run = 0;
      for (int n = 0; n < 600; n++) begin
        bit v;
        bit a;
        if (idle_run > 0) begin
          v = 1'b0;
          idle_run--;
        end else begin
          if ($urandom_range(0, 11) == 0) idle_run = $urandom_range(1, 5);
          v = ($urandom_range(0, 3) != 0);
        end
        a = ($urandom_range(0, 19) == 0);
        drive(v, a, WIDTH'($urandom));
        chk_model($sformatf("rnd%0d", n));
      end
    end
    chk("final.exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
